fwrisc_regfile_np: RTL and testbench

Parametrised multi-read-port register file for the fwrisc core and its coprocessors, the generalised successor to the two-read/one-write integer register file. Width, depth and read-port count are configurable; every read port has a registered output, index 0 is optionally hardwired to zero, and a post-reset scrub state machine clears every entry before the file accepts writes. It sits between decode (read addresses) and writeback (write port).

---
 rtl/fwrisc_regfile_np.sv | 116 +++++++++++
 tb/tb_fwrisc_regfile_np.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fwrisc_regfile_np.sv
// fwrisc_regfile_np: parametrised multi-read-port register file with
// registered read ports, optional hardwired-zero index 0, and a post-reset
// scrub that clears every entry before writes are accepted.
// Build option: FWRISC_REGFILE_BYPASS_EN selects write-first forwarding on a
// same-edge read/write collision; undefined gives read-first behaviour.
module fwrisc_regfile_np #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 6,
    parameter int unsigned NUM_RD_PORTS = 2,
    parameter int unsigned ZERO_REG     = 1
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [NUM_RD_PORTS*ADDR_WIDTH-1:0] rd_raddr,
    output logic [NUM_RD_PORTS*DATA_WIDTH-1:0] rd_rdata,
    input  logic [ADDR_WIDTH-1:0]              wr_addr,
    input  logic [DATA_WIDTH-1:0]              wr_data,
    input  logic                               wr_en,
    output logic                               init_done
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {
        ST_SCRUB = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t                             state;
    state_t                             state_nxt;
    logic [ADDR_WIDTH-1:0]              scrub_cnt;
    logic [ADDR_WIDTH-1:0]              scrub_cnt_nxt;
    logic                               init_done_nxt;
    logic [NUM_RD_PORTS*DATA_WIDTH-1:0] rd_rdata_nxt;

    logic                               mem_we;
    logic [ADDR_WIDTH-1:0]              mem_waddr;
    logic [DATA_WIDTH-1:0]              mem_wdata;
    logic [DATA_WIDTH-1:0]              mem [DEPTH];

    // Next-state, array write port selection and read-data muxing.
    always_comb begin
        logic                  wr_ok;
        logic [ADDR_WIDTH-1:0] raddr;
        logic [DATA_WIDTH-1:0] rdat;

        state_nxt     = state;
        scrub_cnt_nxt = scrub_cnt;
        init_done_nxt = init_done;
        rd_rdata_nxt  = '0;
        mem_we        = 1'b0;
        mem_waddr     = scrub_cnt;
        mem_wdata     = '0;
        wr_ok         = 1'b0;
        raddr         = '0;
        rdat          = '0;

        case (state)
            ST_SCRUB: begin
                // Clear one entry per edge; user writes are dropped and
                // read data is held at zero until the scrub finishes.
                mem_we        = 1'b1;
                scrub_cnt_nxt = scrub_cnt + ADDR_WIDTH'(1);
                if (scrub_cnt == ADDR_WIDTH'(DEPTH - 1)) begin
                    state_nxt     = ST_READY;
                    init_done_nxt = 1'b1;
                end
            end
            ST_READY: begin
                wr_ok     = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));
                mem_we    = wr_ok;
                mem_waddr = wr_addr;
                mem_wdata = wr_data;
                for (int unsigned p = 0; p < NUM_RD_PORTS; p++) begin
                    raddr = rd_raddr[p*ADDR_WIDTH +: ADDR_WIDTH];
                    rdat  = mem[raddr];
`ifdef FWRISC_REGFILE_BYPASS_EN
                    if (wr_ok && (wr_addr == raddr)) begin
                        rdat = wr_data;
                    end
`endif
                    if ((ZERO_REG != 0) && (raddr == '0)) begin
                        rdat = '0;
                    end
                    rd_rdata_nxt[p*DATA_WIDTH +: DATA_WIDTH] = rdat;
                end
            end
            default: begin
                state_nxt = ST_SCRUB;
            end
        endcase
    end

    // Control state and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= ST_SCRUB;
            scrub_cnt <= '0;
            init_done <= 1'b0;
            rd_rdata  <= '0;
        end else begin
            state     <= state_nxt;
            scrub_cnt <= scrub_cnt_nxt;
            init_done <= init_done_nxt;
            rd_rdata  <= rd_rdata_nxt;
        end
    end

    // Storage array; cleared by the scrub rather than by reset.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_fwrisc_regfile_np.sv
// Scoreboard bench for fwrisc_regfile_np: one instance with ZERO_REG=1 and
// one with ZERO_REG=0 share all inputs. Read expectations are queued with
// the issue cycle; a monitor pops and compares them one cycle later.
module tb_fwrisc_regfile_np;

`ifdef FWRISC_REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clock;
    logic        reset;
    logic [11:0] rd_raddr;
    logic [5:0]  wr_addr;
    logic [31:0] wr_data;
    logic        wr_en;
    logic [63:0] rdata0;
    logic [63:0] rdata1;
    logic        init0;
    logic        init1;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int mon_tag = -1;

    typedef struct {
        int          tag;
        int          inst;
        int          port;
        logic [31:0] exp;
    } exp_t;

    exp_t  q[$];
    string nq[$];

    fwrisc_regfile_np dut0 (
        .clock    (clock),
        .reset    (reset),
        .rd_raddr (rd_raddr),
        .rd_rdata (rdata0),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_en    (wr_en),
        .init_done(init0)
    );

    fwrisc_regfile_np #(.ZERO_REG(0)) dut1 (
        .clock    (clock),
        .reset    (reset),
        .rd_raddr (rd_raddr),
        .rd_rdata (rdata1),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_en    (wr_en),
        .init_done(init1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Cycle counter; mon_tag names the issue cycle whose data is now visible.
    always @(posedge clock) begin
        mon_tag <= cyc;
        cyc     <= cyc + 1;
    end

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rd_of(int inst, int port);
        if (inst == 0) return rdata0[port*32 +: 32];
        return rdata1[port*32 +: 32];
    endfunction

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic set_rd(int port, int addr);
        rd_raddr[port*6 +: 6] = 6'(addr);
    endtask

    task automatic expect_rd(int inst, int port, logic [31:0] exp, string name);
        exp_t e;
        e.tag  = cyc;
        e.inst = inst;
        e.port = port;
        e.exp  = exp;
        q.push_back(e);
        nq.push_back(name);
    endtask

    task automatic do_wr(int addr, logic [31:0] data);
        wr_en   = 1'b1;
        wr_addr = 6'(addr);
        wr_data = data;
        step();
        wr_en   = 1'b0;
    endtask

    // Monitor: compare every expectation whose issue cycle has completed.
    always @(negedge clock) begin
        exp_t  e;
        string nm;
        while (q.size() > 0 && q[0].tag <= mon_tag) begin
            e  = q.pop_front();
            nm = nq.pop_front();
            if (e.tag < mon_tag) check({nm, "_late"}, 64'(e.tag), 64'(mon_tag));
            else check(nm, 64'(rd_of(e.inst, e.port)), 64'(e.exp));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b0;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        rd_raddr = '0;
        repeat (3) @(negedge clock);
        check("reset_rdata0", rdata0, 64'h0);
        check("reset_init0", 64'(init0), 64'h0);
        check("reset_init1", 64'(init1), 64'h0);

        // Scrub timing with a write attempt on edge 10.
        reset = 1'b1;
        for (int i = 1; i <= 64; i++) begin
            wr_en   = (i == 10);
            wr_addr = 6'd5;
            wr_data = 32'hDEADBEEF;
            step();
            check("scrub_init", 64'(init0), 64'(i == 64));
        end
        wr_en = 1'b0;
        check("scrub_init1", 64'(init1), 64'h1);

        // Every entry reads zero after the scrub, including address 5.
        for (int a = 0; a < 64; a++) begin
            set_rd(0, a);
            set_rd(1, 63 - a);
            expect_rd(0, 0, 32'h0, "scrub_rd_p0");
            expect_rd(1, 1, 32'h0, "scrub_rd_p1_z0");
            step();
        end

        // Basic write then both ports reading the same address.
        do_wr(7, 32'h12345678);
        set_rd(0, 7);
        set_rd(1, 7);
        expect_rd(0, 0, 32'h12345678, "basic_p0");
        expect_rd(0, 1, 32'h12345678, "basic_p1");
        step();

        do_wr(1, 32'hA5A5A5A5);
        do_wr(63, 32'h5A5A5A5A);
        do_wr(32, 32'h80000001);
        set_rd(0, 63);
        set_rd(1, 1);
        expect_rd(0, 0, 32'h5A5A5A5A, "top_addr_p0");
        expect_rd(0, 1, 32'hA5A5A5A5, "addr1_p1");
        step();
        set_rd(0, 32);
        set_rd(1, 7);
        expect_rd(0, 0, 32'h80000001, "addr32_p0");
        expect_rd(1, 1, 32'h12345678, "addr7_p1_z0");
        step();

        // Index 0: hardwired zero in dut0, ordinary entry in dut1.
        do_wr(0, 32'hFFFFFFFF);
        set_rd(0, 0);
        set_rd(1, 0);
        expect_rd(0, 0, 32'h0, "zero_reg_p0");
        expect_rd(0, 1, 32'h0, "zero_reg_p1");
        expect_rd(1, 0, 32'hFFFFFFFF, "no_zero_reg_p0");
        step();

        // Same-edge collision on address 9.
        do_wr(9, 32'h1);
        wr_en   = 1'b1;
        wr_addr = 6'd9;
        wr_data = 32'h2;
        set_rd(0, 7);
        set_rd(1, 9);
        expect_rd(0, 1, BYP ? 32'h2 : 32'h1, "collide_p1");
        expect_rd(0, 0, 32'h12345678, "collide_other_p0");
        step();
        wr_en = 1'b0;
        expect_rd(0, 1, 32'h2, "after_collide_p1");
        step();

        // Collision on index 0: masked in dut0 in either build.
        wr_en   = 1'b1;
        wr_addr = 6'd0;
        wr_data = 32'h5;
        set_rd(0, 0);
        set_rd(1, 1);
        expect_rd(0, 0, 32'h0, "zero_collide_p0");
        expect_rd(1, 0, BYP ? 32'h5 : 32'hFFFFFFFF, "zero_collide_z0");
        step();
        wr_en = 1'b0;
        expect_rd(1, 0, 32'h5, "after_zero_collide_z0");
        expect_rd(0, 1, 32'hA5A5A5A5, "hold_p1");
        step();
        step();

        // Reset mid-operation clears outputs immediately.
        reset = 1'b0;
        #1;
        check("midop_rdata0", rdata0, 64'h0);
        check("midop_rdata1", rdata1, 64'h0);
        check("midop_init0", 64'(init0), 64'h0);
        check("midop_init1", 64'(init1), 64'h0);
        repeat (3) step();
        reset = 1'b1;

        // Reset at scrub edge 30, held 3 cycles, then a full rescrub.
        repeat (30) step();
        check("mid_scrub_init", 64'(init0), 64'h0);
        reset = 1'b0;
        #1;
        check("mid_scrub_rdata0", rdata0, 64'h0);
        check("mid_scrub_init0", 64'(init0), 64'h0);
        repeat (3) step();
        reset = 1'b1;
        for (int i = 1; i <= 64; i++) begin
            step();
            check("rescrub_init", 64'(init0), 64'(i == 64));
        end

        set_rd(0, 9);
        set_rd(1, 63);
        expect_rd(0, 0, 32'h0, "rescrub_addr9");
        expect_rd(0, 1, 32'h0, "rescrub_addr63");
        expect_rd(1, 0, 32'h0, "rescrub_addr9_z0");
        step();
        step();
        step();
        check("queue_drained", 64'(q.size()), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
